// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings, state type and alignment rule for the data-memory responder
package dm_pkg;

   // Access size encodings carried on ReqSize
   localparam logic [1:0] DM_WORD    = 2'b00;
   localparam logic [1:0] DM_HALF    = 2'b01;
   localparam logic [1:0] DM_BYTE    = 2'b10;
   localparam logic [1:0] DM_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      DM_IDLE = 2'd0,
      DM_WAIT = 2'd1,
      DM_RESP = 2'd2
   } dm_state_t;

   // Halves need an even address, words need a 4-byte aligned address
   function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return ((size == DM_HALF) && addr_lo[0]) ||
             ((size == DM_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - little-endian lane steering for stores and extension for loads
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic        sign_ext,
   input  logic [31:0] rdata,
   output logic [3:0]  wmask,
   output logic [31:0] wword,
   output logic [31:0] rdata_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store side: replicate the low bits onto every lane and enable only the addressed ones
   always_comb begin
      wmask = 4'b0000;
      wword = wdata;
      case (size)
         DM_BYTE: begin
            wmask = 4'b0001 << addr_lo;
            wword = {4{wdata[7:0]}};
         end
         DM_HALF: begin
            wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
         end
         DM_WORD: begin
            wmask = 4'b1111;
            wword = wdata;
         end
         default: begin
            wmask = 4'b0000;
            wword = wdata;
         end
      endcase
   end

   // Load side: pick the addressed byte or half and sign- or zero-extend it
   always_comb begin
      byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
      half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      rdata_ext = 32'h0;
      case (size)
         DM_BYTE: rdata_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         DM_HALF: rdata_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
         DM_WORD: rdata_ext = rdata;
         default: rdata_ext = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle load/store responder with valid/ready request and response channels
module data_mem_responder
   import dm_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 2
)(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [1:0]        ReqSize,
   input  logic              ReqSigned,
   input  logic [31:0]       ReqWData,
   output logic              RspValid,
   input  logic              RspReady,
   output logic [31:0]       RspData,
   output logic              RspError
);

   localparam int         DEPTH     = 2 ** (ADDR_W - 2);
   // The accept edge already counts as one cycle, so the counter starts at
   // WAIT_CYCLES and the access happens on the edge that finds it at zero;
   // this gives RspValid after accept edge + WAIT_CYCLES + 1.
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   dm_state_t          state;
   logic [3:0]         cnt;

   logic               lat_write;
   logic [ADDR_W-1:0]  lat_addr;
   logic [1:0]         lat_size;
   logic               lat_signed;
   logic [31:0]        lat_wdata;
   logic               lat_err;

   logic [31:0]        mem [DEPTH];

   logic [ADDR_W-3:0]  idx;
   logic [31:0]        rd_word;
   logic [3:0]         wmask;
   logic [31:0]        wword;
   logic [31:0]        load_data;
   logic               req_err;
   logic               access;
   logic               mem_we;

   assign idx     = lat_addr[ADDR_W-1:2];
   assign rd_word = mem[idx];
   assign req_err = (ReqSize == DM_ILLEGAL) || dm_misaligned(ReqSize, ReqAddr[1:0]);
   assign access  = (state == DM_WAIT) && (cnt == 4'd0);
   assign mem_we  = access && lat_write && !lat_err && !Rst;

   dm_lane_align u_lane_align (
      .size      (lat_size),
      .addr_lo   (lat_addr[1:0]),
      .wdata     (lat_wdata),
      .sign_ext  (lat_signed),
      .rdata     (rd_word),
      .wmask     (wmask),
      .wword     (wword),
      .rdata_ext (load_data)
   );

   // Request/response FSM with registered handshake outputs and the wait counter
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= DM_IDLE;
         ReqReady   <= 1'b1;
         RspValid   <= 1'b0;
         RspData    <= 32'h0;
         RspError   <= 1'b0;
         cnt        <= 4'd0;
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_size   <= DM_WORD;
         lat_signed <= 1'b0;
         lat_wdata  <= 32'h0;
         lat_err    <= 1'b0;
      end else begin
         case (state)
            DM_IDLE: begin
               if (ReqValid && ReqReady) begin
                  lat_write  <= ReqWrite;
                  lat_addr   <= ReqAddr;
                  lat_size   <= ReqSize;
                  lat_signed <= ReqSigned;
                  lat_wdata  <= ReqWData;
                  lat_err    <= req_err;
                  // Errors skip the programmable delay and respond one edge later
                  cnt        <= req_err ? 4'd0 : WAIT_LOAD;
                  ReqReady   <= 1'b0;
                  state      <= DM_WAIT;
               end
            end
            DM_WAIT: begin
               if (cnt == 4'd0) begin
                  RspValid <= 1'b1;
                  RspError <= lat_err;
                  RspData  <= (lat_err || lat_write) ? 32'h0 : load_data;
                  state    <= DM_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DM_RESP: begin
               if (RspReady) begin
                  RspValid <= 1'b0;
                  RspData  <= 32'h0;
                  RspError <= 1'b0;
                  ReqReady <= 1'b1;
                  state    <= DM_IDLE;
               end
            end
            default: begin
               ReqReady <= 1'b1;
               RspValid <= 1'b0;
               state    <= DM_IDLE;
            end
         endcase
      end
   end

   // Array write of the enabled lanes; contents are intentionally not reset
   always_ff @(posedge Clk) begin
      if (mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (wmask[k]) begin
               mem[idx][8*k +: 8] <= wword[8*k +: 8];
            end
         end
      end
   end

endmodule
